// File: rtl/ahb_cmd_pkg.sv
// ahb_cmd_pkg: shared definitions for the ahb_top command sequencer.
//   - seq_state_t : sequencer FSM state encoding
//   - command word layout helpers. A command word is packed as
//       {dinb, dina, addr, sel[1:0], wr}
//     with wr at bit 0, sel at bits [2:1] and addr starting at bit 3.
//   - DEF_READ_BEATS : default read wait length
package ahb_cmd_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_W_ADDR = 3'd1,
    S_W_DATA = 3'd2,
    S_R_ADDR = 3'd3,
    S_R_WAIT = 3'd4,
    S_R_CAP  = 3'd5
  } seq_state_t;

  localparam int DEF_READ_BEATS = 3;

  localparam int CMD_WR_BIT   = 0;
  localparam int CMD_SEL_LSB  = 1;
  localparam int CMD_ADDR_LSB = 3;

  function automatic int cmd_dina_lsb(input int aw);
    return 3 + aw;
  endfunction

  function automatic int cmd_dinb_lsb(input int aw, input int dw);
    return 3 + aw + dw;
  endfunction

  function automatic int cmd_width(input int aw, input int dw);
    return 3 + aw + 2 * dw;
  endfunction

endpackage

// File: rtl/ahb_cmd_seq_fifo.sv
// cmd_fifo: synchronous FIFO holding packed command words.
// Ports:
//   i_clk, i_rst       clock, asynchronous active-high reset
//   i_push, i_din      write side; a push while full is dropped
//   i_pop, o_dout      read side; o_dout shows the head entry (fall-through)
//   o_full, o_empty    status
// Pointers carry one extra wrap bit: equal pointers mean empty, pointers
// that differ only in the wrap bit mean full.
module cmd_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_push,
  input  logic [W-1:0] i_din,
  input  logic         i_pop,
  output logic [W-1:0] o_dout,
  output logic         o_full,
  output logic         o_empty
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0]  r_wptr;
  logic [PW:0]  r_rptr;
  logic [W-1:0] r_mem [DEPTH];
  logic         w_push;
  logic         w_pop;

  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[PW] != r_rptr[PW]) &&
                   (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_dout  = r_mem[r_rptr[PW-1:0]];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + (PW+1)'(1);
      if (w_pop)  r_rptr <= r_rptr + (PW+1)'(1);
    end
  end

  // Storage needs no reset: an entry is only read after it was written.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr[PW-1:0]] <= i_din;
  end

endmodule

// File: rtl/ahb_cmd_seq.sv
// ahb_cmd_seq: buffers write/read commands and replays them onto the
// ahb_top user pins with ahb_top's cycle timing.
// Ports:
//   hclk, hreset                      clock, async active-high reset
//   cmd_valid/cmd_ready               command handshake
//   cmd_wr, cmd_sel, cmd_addr,
//   cmd_dina, cmd_dinb                command payload
//   enable, wr, slave_sel, addr,
//   dina, dinb                        registered drive to ahb_top
//   dout                              read data from ahb_top
//   rsp_valid, rsp_data               one-cycle read response, data held
//   busy                              FSM active or commands pending
//   dbg_state                         current FSM state
//   wr_count, rd_count                completion counters, present only when
//                                     AHB_CMD_SEQ_STATS_EN is defined
// Handshake: a command is taken on a rising edge where cmd_valid and
// cmd_ready are both high; cmd_ready is low only while the FIFO is full.
// There is no response back-pressure.
module ahb_cmd_seq
  import ahb_cmd_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int READ_BEATS = DEF_READ_BEATS,
  parameter int AW         = 32,
  parameter int DW         = 32
) (
  input  logic          hclk,
  input  logic          hreset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_wr,
  input  logic [1:0]    cmd_sel,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_dina,
  input  logic [DW-1:0] cmd_dinb,
  output logic          enable,
  output logic          wr,
  output logic [1:0]    slave_sel,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] dina,
  output logic [DW-1:0] dinb,
  input  logic [DW-1:0] dout,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_data,
  output logic          busy,
  output seq_state_t    dbg_state
`ifdef AHB_CMD_SEQ_STATS_EN
  ,
  output logic [15:0]   wr_count,
  output logic [15:0]   rd_count
`endif
);

  localparam int CMDW  = cmd_width(AW, DW);
  localparam int A_LSB = cmd_dina_lsb(AW);
  localparam int B_LSB = cmd_dinb_lsb(AW, DW);
  localparam int CNTW  = (READ_BEATS < 2) ? 1 : $clog2(READ_BEATS + 1);

  seq_state_t      r_state;
  seq_state_t      w_next;
  logic            w_pop;
  logic            w_full;
  logic            w_empty;
  logic [CMDW-1:0] w_cmd_in;
  logic [CMDW-1:0] w_cmd_head;
  logic [CNTW-1:0] r_cnt;
  logic [DW-1:0]   r_stage_a;
  logic [DW-1:0]   r_stage_b;
  logic            r_enable;
  logic            r_wr;
  logic [1:0]      r_sel;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_dina;
  logic [DW-1:0]   r_dinb;
  logic            r_rsp_valid;
  logic [DW-1:0]   r_rsp_data;

  assign w_cmd_in = {cmd_dinb, cmd_dina, cmd_addr, cmd_sel, cmd_wr};

  cmd_fifo #(.W(CMDW), .DEPTH(DEPTH)) u_fifo (
    .i_clk   (hclk),
    .i_rst   (hreset),
    .i_push  (cmd_valid),
    .i_din   (w_cmd_in),
    .i_pop   (w_pop),
    .o_dout  (w_cmd_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign cmd_ready = !w_full;
  assign busy      = (r_state != S_IDLE) || !w_empty;
  assign dbg_state = r_state;
  assign enable    = r_enable;
  assign wr        = r_wr;
  assign slave_sel = r_sel;
  assign addr      = r_addr;
  assign dina      = r_dina;
  assign dinb      = r_dinb;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop  = 1'b1;
          w_next = w_cmd_head[CMD_WR_BIT] ? S_W_ADDR : S_R_ADDR;
        end
      end
      S_W_ADDR: w_next = S_W_DATA;
      S_W_DATA: w_next = S_IDLE;
      S_R_ADDR: w_next = S_R_WAIT;
      S_R_WAIT: if (r_cnt == CNTW'(1)) w_next = S_R_CAP;
      S_R_CAP:  w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Bus pins are registered from the next state, so each pin pattern lines
  // up with the state cycle it belongs to and always comes from a flop.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      r_enable    <= 1'b0;
      r_wr        <= 1'b0;
      r_sel       <= '0;
      r_addr      <= '0;
      r_dina      <= '0;
      r_dinb      <= '0;
      r_stage_a   <= '0;
      r_stage_b   <= '0;
      r_cnt       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      r_enable <= (w_next != S_IDLE);
      case (w_next)
        S_W_DATA:                             r_wr <= 1'b1;
        S_W_ADDR, S_R_ADDR, S_R_WAIT, S_R_CAP: r_wr <= 1'b0;
        default:                              r_wr <= r_wr;
      endcase
      // The popped entry leaves the FIFO, so its write operands are staged
      // until W_ADDR moves them onto dina/dinb.
      if (w_pop) begin
        r_sel     <= w_cmd_head[CMD_SEL_LSB +: 2];
        r_addr    <= w_cmd_head[CMD_ADDR_LSB +: AW];
        r_stage_a <= w_cmd_head[A_LSB +: DW];
        r_stage_b <= w_cmd_head[B_LSB +: DW];
      end
      if (r_state == S_W_ADDR) begin
        r_dina <= r_stage_a;
        r_dinb <= r_stage_b;
      end
      if (r_state == S_R_ADDR)      r_cnt <= CNTW'(READ_BEATS);
      else if (r_state == S_R_WAIT) r_cnt <= r_cnt - CNTW'(1);
      r_rsp_valid <= (r_state == S_R_CAP);
      if (r_state == S_R_CAP) r_rsp_data <= dout;
    end
  end

`ifdef AHB_CMD_SEQ_STATS_EN
  logic [15:0] r_wr_count;
  logic [15:0] r_rd_count;

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      r_wr_count <= '0;
      r_rd_count <= '0;
    end else begin
      if (r_state == S_W_DATA) r_wr_count <= r_wr_count + 16'd1;
      if (r_rsp_valid)         r_rd_count <= r_rd_count + 16'd1;
    end
  end

  assign wr_count = r_wr_count;
  assign rd_count = r_rd_count;
`endif

endmodule

// File: tb/tb_ahb_cmd_seq.sv
// tb_ahb_cmd_seq: bench for ahb_cmd_seq. A small stand-in for ahb_top
// returns addr+2 on dout only in the fifth enable cycle of a read. Every
// accepted command queues its expected bus burst (and read response); a
// monitor on the falling edge rebuilds each enable burst and each response
// and compares them against the queues.
// Define AHB_CMD_SEQ_STATS_EN to also exercise wr_count/rd_count.
module tb_ahb_cmd_seq;
  import ahb_cmd_pkg::*;

  logic        hclk = 1'b0;
  logic        hreset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_wr;
  logic [1:0]  cmd_sel;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_dina;
  logic [31:0] cmd_dinb;
  logic        enable;
  logic        wr;
  logic [1:0]  slave_sel;
  logic [31:0] addr;
  logic [31:0] dina;
  logic [31:0] dinb;
  logic [31:0] dout;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        busy;
  seq_state_t  dbg_state;
`ifdef AHB_CMD_SEQ_STATS_EN
  logic [15:0] wr_count;
  logic [15:0] rd_count;
`endif

  ahb_cmd_seq #(.DEPTH(4), .READ_BEATS(3), .AW(32), .DW(32)) dut (
    .hclk      (hclk),
    .hreset    (hreset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_wr    (cmd_wr),
    .cmd_sel   (cmd_sel),
    .cmd_addr  (cmd_addr),
    .cmd_dina  (cmd_dina),
    .cmd_dinb  (cmd_dinb),
    .enable    (enable),
    .wr        (wr),
    .slave_sel (slave_sel),
    .addr      (addr),
    .dina      (dina),
    .dinb      (dinb),
    .dout      (dout),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .dbg_state (dbg_state)
`ifdef AHB_CMD_SEQ_STATS_EN
    ,
    .wr_count  (wr_count),
    .rd_count  (rd_count)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 hclk = ~hclk;

  // ---------------- ahb_top stand-in ----------------
  logic [7:0] en_run;
  always @(posedge hclk or posedge hreset) begin
    if (hreset)      en_run <= 8'd0;
    else if (enable) en_run <= en_run + 8'd1;
    else             en_run <= 8'd0;
  end
  assign dout = (enable && en_run == 8'd4) ? addr + 32'd2 : 32'hBAD0_0000;

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic        wr;
    logic [1:0]  sel;
    logic [31:0] addr;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  gap;   // required enable-low cycles before burst, 0 = any
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] rsp_q[$];
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, req, $time);
    end
  endtask

  // ---------------- monitor ----------------
  logic        in_burst = 1'b0;
  logic        prev_rsp = 1'b0;
  int          gap = 15;
  int          gap_rec;
  int          len;
  logic        wr_first, wr_last;
  logic [1:0]  sel_s;
  logic [31:0] addr_s, a_s, b_s;

  task automatic compare_burst();
    exp_t e;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL burst_unexpected actual=addr %0h required=none", addr_s);
    end else begin
      e = exp_q.pop_front();
      check("burst_wr_first", 32'(wr_first), 32'd0);
      check("burst_wr_last", 32'(wr_last), 32'(e.wr));
      check("burst_len", 32'(len), e.wr ? 32'd2 : 32'd5);
      check("burst_sel", 32'(sel_s), 32'(e.sel));
      check("burst_addr", addr_s, e.addr);
      if (e.wr) begin
        check("burst_dina", a_s, e.a);
        check("burst_dinb", b_s, e.b);
      end
      if (e.gap != 4'd0) check("burst_gap", 32'(gap_rec), 32'(e.gap));
    end
  endtask

  always @(negedge hclk) begin
    if (hreset) begin
      in_burst = 1'b0;
      prev_rsp = 1'b0;
      gap      = 15;
    end else begin
      if (rsp_valid) begin
        check("rsp_one_cycle", 32'(prev_rsp), 32'd0);
        if (rsp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL rsp_unexpected actual=%0h required=none", rsp_data);
        end else begin
          check("rsp_data", rsp_data, rsp_q.pop_front());
        end
      end
      prev_rsp = rsp_valid;
      if (enable) begin
        if (!in_burst) begin
          in_burst = 1'b1;
          len      = 0;
          gap_rec  = gap;
          wr_first = wr;
          sel_s    = slave_sel;
          addr_s   = addr;
        end
        len++;
        wr_last = wr;
        a_s     = dina;
        b_s     = dinb;
      end else begin
        if (in_burst) begin
          in_burst = 1'b0;
          compare_burst();
          gap = 0;
        end
        if (gap < 15) gap++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_cmd(input logic w, input logic [1:0] s, input logic [31:0] ad,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] rsp, input logic [3:0] g);
    @(negedge hclk);
    cmd_valid = 1'b1;
    cmd_wr    = w;
    cmd_sel   = s;
    cmd_addr  = ad;
    cmd_dina  = a;
    cmd_dinb  = b;
    check("push_ready", 32'(cmd_ready), 32'd1);
    if (cmd_ready) begin
      exp_q.push_back('{wr: w, sel: s, addr: ad, a: a, b: b, gap: g});
      if (!w) rsp_q.push_back(rsp);
    end
    @(posedge hclk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int k;
    for (k = 0; k < bound; k++) begin
      @(negedge hclk);
      if (!busy && exp_q.size() == 0 && rsp_q.size() == 0) break;
    end
    check("idle_timeout", 32'(k < bound), 32'd1);
    repeat (2) @(negedge hclk);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int k;
    logic [2:0] fifo_cnt;
    hreset    = 1'b1;
    cmd_valid = 1'b0;
    cmd_wr    = 1'b0;
    cmd_sel   = 2'd0;
    cmd_addr  = 32'd0;
    cmd_dina  = 32'd0;
    cmd_dinb  = 32'd0;
    repeat (3) @(posedge hclk);
    @(negedge hclk);
    check("rst_enable", 32'(enable), 32'd0);
    check("rst_wr", 32'(wr), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_slave_sel", 32'(slave_sel), 32'd0);
    check("rst_addr", addr, 32'd0);
    check("rst_dina", dina, 32'd0);
    check("rst_dinb", dinb, 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    hreset = 1'b0;

    // Single write, then single read returning 3.
    push_cmd(1'b1, 2'd0, 32'd1, 32'd1, 32'd2, 32'd0, 4'd0);
    wait_idle(40);
    push_cmd(1'b0, 2'd0, 32'd1, 32'd0, 32'd0, 32'd3, 4'd0);
    wait_idle(40);

    // A read occupies the FSM while four writes fill the FIFO.
    push_cmd(1'b0, 2'd2, 32'h0000_00F0, 32'd0, 32'd0, 32'h0000_00F2, 4'd0);
    for (int i = 0; i < 4; i++)
      push_cmd(1'b1, 2'(i), 32'(i + 1), 32'h10 + 32'(i), 32'h20 + 32'(i), 32'd0, 4'd1);
    // Fifth command is offered and held until the FSM pops from the full FIFO.
    @(negedge hclk);
    cmd_valid = 1'b1;
    cmd_wr    = 1'b1;
    cmd_sel   = 2'd3;
    cmd_addr  = 32'h99;
    cmd_dina  = 32'h77;
    cmd_dinb  = 32'h88;
    check("full_ready_low", 32'(cmd_ready), 32'd0);
    for (k = 0; k < 20; k++) begin
      if (dbg_state == S_IDLE && !cmd_ready) break;
      @(negedge hclk);
    end
    check("pop_from_full_seen", 32'(k < 20), 32'd1);
    @(posedge hclk);
    #1;
    cmd_valid = 1'b0;
    fifo_cnt = dut.u_fifo.r_wptr - dut.u_fifo.r_rptr;
    check("fifo_count_after_pop", 32'(fifo_cnt), 32'd3);
    check("ready_after_pop", 32'(cmd_ready), 32'd1);
    wait_idle(80);

    // Reset in the middle of a read wait.
    push_cmd(1'b0, 2'd1, 32'h40, 32'd0, 32'd0, 32'h42, 4'd0);
    for (k = 0; k < 20; k++) begin
      @(negedge hclk);
      if (dbg_state == S_R_WAIT) break;
    end
    check("reach_r_wait", 32'(k < 20), 32'd1);
    #2 hreset = 1'b1;
    #1;
    check("abort_enable", 32'(enable), 32'd0);
    check("abort_wr", 32'(wr), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_ready", 32'(cmd_ready), 32'd1);
    fifo_cnt = dut.u_fifo.r_wptr - dut.u_fifo.r_rptr;
    check("abort_fifo_empty", 32'(fifo_cnt), 32'd0);
    exp_q.delete();
    rsp_q.delete();
    repeat (2) @(negedge hclk);
    hreset = 1'b0;
    repeat (6) begin
      @(negedge hclk);
      check("abort_no_rsp", 32'(rsp_valid), 32'd0);
    end

    // Stream of 2 writes and 3 reads after the abort.
    push_cmd(1'b1, 2'd2, 32'h100, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 32'd0, 4'd0);
    push_cmd(1'b1, 2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 4'd1);
    push_cmd(1'b0, 2'd1, 32'h10, 32'd0, 32'd0, 32'h12, 4'd1);
    push_cmd(1'b0, 2'd2, 32'hFFFF_FFFE, 32'd0, 32'd0, 32'h0, 4'd1);
    push_cmd(1'b0, 2'd3, 32'h7, 32'd0, 32'd0, 32'h9, 4'd1);
    wait_idle(120);

`ifdef AHB_CMD_SEQ_STATS_EN
    check("stats_wr_count", 32'(wr_count), 32'd2);
    check("stats_rd_count", 32'(rd_count), 32'd3);
    @(negedge hclk);
    force dut.r_wr_count = 16'hFFFF;
    #1 release dut.r_wr_count;
    push_cmd(1'b1, 2'd1, 32'h55, 32'h1, 32'h2, 32'd0, 4'd0);
    wait_idle(40);
    check("stats_wr_wrap", 32'(wr_count), 32'd0);
`endif

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("rsp_q_drained", 32'(rsp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ahb_cmd_seq.md
Name: ahb_cmd_seq

Overview:
Command sequencer that sits directly upstream of ahb_top. It accepts write/read commands on a valid/ready interface and buffers them in a small FIFO. It replays each command onto ahb_top's user pins (enable, wr, slave_sel, addr, dina, dinb) with the exact multi-cycle timing ahb_top requires. It captures ahb_top's dout at the end of each read and returns it as a one-cycle response.

Parameters:
DEPTH, 4, command FIFO entries (power of two, >=2)
READ_BEATS, 3, wait cycles between read address phase and dout capture
AW, 32, address width
DW, 32, data width

Ports:
hclk  input  1  clock; all logic on rising edge
hreset  input  1  asynchronous reset, active-high
cmd_valid  input  1  command offered
cmd_ready  output  1  FIFO can accept (= !full)
cmd_wr  input  1  1 = write, 0 = read
cmd_sel  input  2  target slave index
cmd_addr  input  AW  target address
cmd_dina  input  DW  write operand A (ignored for reads)
cmd_dinb  input  DW  write operand B (ignored for reads)
enable  output  1  to ahb_top enable
wr  output  1  to ahb_top wr
slave_sel  output  2  to ahb_top slave_sel
addr  output  AW  to ahb_top addr
dina  output  DW  to ahb_top dina
dinb  output  DW  to ahb_top dinb
dout  input  DW  read data from ahb_top
rsp_valid  output  1  one-cycle pulse, read data available
rsp_data  output  DW  captured read data, held until next capture
busy  output  1  FSM not IDLE or FIFO not empty

Behaviour:
- Reset (async, immediate): FIFO emptied, FSM to IDLE. enable, wr, rsp_valid, busy = 0; slave_sel, addr, dina, dinb, rsp_data = 0. cmd_ready = 1 after reset.
- A command is pushed on a rising edge with cmd_valid && cmd_ready. Push and pop in the same cycle are legal when not full. When full, cmd_ready = 0 and cmd_valid is ignored.
- All outputs to ahb_top are registered. addr, slave_sel, dina and dinb hold their last value when not being updated.
- FSM states: IDLE, W_ADDR, W_DATA, R_ADDR, R_WAIT, R_CAP.
- IDLE: enable = 0, wr unchanged. If FIFO not empty: pop, load addr and slave_sel, go to W_ADDR if cmd_wr else R_ADDR.
- W_ADDR (1 cycle): enable = 1, wr = 0. Load dina/dinb. Go to W_DATA.
- W_DATA (1 cycle): enable = 1, wr = 1. Go to IDLE. Net result: enable is high for 2 cycles, and wr rises in the second.
- R_ADDR (1 cycle): enable = 1, wr = 0. Load the wait counter with READ_BEATS, go to R_WAIT.
- R_WAIT: enable = 1, wr = 0. Decrement the counter each cycle; at 1, go to R_CAP.
- R_CAP (1 cycle): enable = 1. dout is sampled into rsp_data on this cycle's closing edge, and rsp_valid pulses for the following cycle. Go to IDLE.
- Read enable-high length = READ_BEATS + 2 cycles (5 at default).
- Between commands the FSM always spends exactly one IDLE cycle with enable = 0, so ahb_top sees an enable drop.
- A command popped in IDLE appears on enable one cycle later. There is no rsp back-pressure: the consumer must take rsp_valid when it pulses.
- Reset asserted mid-command aborts the transfer: enable drops asynchronously and no rsp_valid is issued.
- FIFO pointers are log2(DEPTH)+1 bits wide. Full/empty use the MSB-differ rule, and pointers wrap modulo 2*DEPTH.

Optional Feature:
AHB_CMD_SEQ_STATS_EN
- Defined: adds outputs wr_count[15:0] and rd_count[15:0]. wr_count increments on each W_DATA exit; rd_count increments on each rsp_valid. Both wrap at 0xFFFF to 0 and clear on reset.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package ahb_cmd_pkg holds: FSM state encoding constants; command word field offsets (wr, sel, addr, dina, dinb, total width = 3+AW+2*DW); the default READ_BEATS.
- Sub-module cmd_fifo: generic synchronous FIFO of width = command word and depth DEPTH, with push/pop/full/empty. The FSM stays in ahb_cmd_seq.

Test Plan:
- After reset, push write sel=0 addr=1 a=1 b=2 -> enable high 2 cycles; wr=0 then 1; addr=1, dina=1, dinb=2; then one cycle with enable=0.
- Push read sel=0 addr=1 with ahb_top returning dout=3 -> enable high exactly 5 cycles; rsp_valid one pulse; rsp_data=3.
- Push 4 commands back-to-back (sel 0..3, addr 1..4) -> cmd_ready falls after the 4th; 5th cmd_valid is ignored; commands are issued in order, each separated by one enable-low cycle.
- Push on the same edge as a pop from a full FIFO -> the push is refused (cmd_ready was 0) and the FIFO count drops to 3.
- Assert hreset during R_WAIT -> enable, wr and busy go 0 without waiting for an edge; no rsp_valid; FIFO empty; the next command runs normally.
- With AHB_CMD_SEQ_STATS_EN: 2 writes and 3 reads -> wr_count=2, rd_count=3. Force wr_count to 0xFFFF, then one more write -> wr_count=0.
